decode_imm_sched: RTL and testbench

Decode-stage sequencer that owns the shared immediate generator. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into the 6-bit one-hot instruction-type code. It drives the immediate generator from a registered stage, captures the sign-extended result and presents {pc, inst_type, immediate, illegal} to execute. The block is a 2-stage elastic pipeline with back-pressure, flush and an illegal-opcode counter.

---
 rtl/decode_imm_sched.sv | 158 +++++++++++++++
 tb/tb_decode_imm_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_sched.sv
`default_nettype none
// ============================================================================
// Module   : decode_imm_sched
// Brief    : Two-stage elastic decode pipeline that owns the shared immediate
//            generator. Stage A registers the fetched instruction together
//            with its one-hot type and feeds the external immediate generator.
//            Stage B captures the generator result and presents the decoded
//            entry to execute. A saturating counter tracks delivered illegal
//            entries.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            flush               - kill all in-flight entries
//            in_valid/in_ready   - fetch handshake (in_inst, in_pc)
//            imm_inst/imm_type   - operands driven to the immediate generator
//            imm_value           - combinational generator result
//            out_valid/out_ready - execute handshake (out_pc, out_type,
//                                  out_imm, out_illegal)
//            illegal_cnt         - saturating count of delivered illegal entries
// Revision : 1.0 - initial release
// ============================================================================
module decode_imm_sched #(
    parameter int LEN   = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_inst,
    input  logic [LEN-1:0]   in_pc,
    output logic [LEN-1:0]   imm_inst,
    output logic [5:0]       imm_type,
    input  logic [LEN-1:0]   imm_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_pc,
    output logic [5:0]       out_type,
    output logic [LEN-1:0]   out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [5:0] C_TYPE_R = 6'b100000;
    localparam logic [5:0] C_TYPE_I = 6'b010000;
    localparam logic [5:0] C_TYPE_S = 6'b001000;
    localparam logic [5:0] C_TYPE_B = 6'b000100;
    localparam logic [5:0] C_TYPE_U = 6'b000010;
    localparam logic [5:0] C_TYPE_J = 6'b000001;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // Stage A
    logic             r_a_valid;
    logic [LEN-1:0]   r_a_inst;
    logic [LEN-1:0]   r_a_pc;
    logic [5:0]       r_a_type;
    logic             r_a_ill;

    // Stage B
    logic             r_b_valid;
    logic [LEN-1:0]   r_b_pc;
    logic [5:0]       r_b_type;
    logic [LEN-1:0]   r_b_imm;
    logic             r_b_ill;

    logic [CNT_W-1:0] r_illegal_cnt;

    logic [5:0]       w_dec_type;
    logic             w_dec_ill;
    logic             w_a_adv;
    logic             w_in_fire;
    logic             w_out_fire;

    // Opcode classification. Unknown opcodes still present an R-type code so
    // the generator never sees an all-zero or multi-hot selector.
    always_comb begin
        w_dec_type = C_TYPE_R;
        w_dec_ill  = 1'b0;
        case (in_inst[6:0])
            7'b0110011:                         w_dec_type = C_TYPE_R;
            7'b0010011, 7'b0000011, 7'b1100111: w_dec_type = C_TYPE_I;
            7'b0100011:                         w_dec_type = C_TYPE_S;
            7'b1100011:                         w_dec_type = C_TYPE_B;
            7'b0110111, 7'b0010111:             w_dec_type = C_TYPE_U;
            7'b1101111:                         w_dec_type = C_TYPE_J;
            default: begin
                w_dec_type = C_TYPE_R;
                w_dec_ill  = 1'b1;
            end
        endcase
    end

    // Stage A moves forward whenever B is empty or B is being drained.
    assign w_a_adv    = r_a_valid & (~r_b_valid | out_ready);
    // rst is folded in so nothing is accepted while the pipeline is being reset.
    assign in_ready   = ~rst & ~flush & (~r_a_valid | w_a_adv);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_b_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid     <= 1'b0;
            r_a_inst      <= '0;
            r_a_pc        <= '0;
            r_a_type      <= C_TYPE_R;
            r_a_ill       <= 1'b0;
            r_b_valid     <= 1'b0;
            r_b_pc        <= '0;
            r_b_type      <= C_TYPE_R;
            r_b_imm       <= '0;
            r_b_ill       <= 1'b0;
            r_illegal_cnt <= '0;
        end else if (flush) begin
            // Entries are discarded, including one handshaking this cycle,
            // so the counter is deliberately left alone.
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_a_valid <= 1'b1;
                r_a_inst  <= in_inst;
                r_a_pc    <= in_pc;
                r_a_type  <= w_dec_type;
                r_a_ill   <= w_dec_ill;
            end else if (w_a_adv) begin
                r_a_valid <= 1'b0;
            end

            if (w_a_adv) begin
                r_b_valid <= 1'b1;
                r_b_pc    <= r_a_pc;
                r_b_type  <= r_a_type;
                // Illegal entries carry a zero immediate regardless of
                // what the generator produced for the forced R type.
                r_b_imm   <= r_a_ill ? '0 : imm_value;
                r_b_ill   <= r_a_ill;
            end else if (w_out_fire) begin
                r_b_valid <= 1'b0;
            end

            if (w_out_fire && r_b_ill && (r_illegal_cnt != C_CNT_MAX)) begin
                r_illegal_cnt <= r_illegal_cnt + C_CNT_ONE;
            end
        end
    end

    assign imm_inst    = r_a_inst;
    assign imm_type    = r_a_type;
    assign out_valid   = r_b_valid;
    assign out_pc      = r_b_pc;
    assign out_type    = r_b_type;
    assign out_imm     = r_b_imm;
    assign out_illegal = r_b_ill;
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_imm_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_imm_sched
// Brief    : Self-checking bench for decode_imm_sched. Supplies an RV32
//            immediate generator, keeps a queue-based reference model of the
//            in-flight entries, and checks the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_imm_sched;

    localparam int LEN   = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [LEN-1:0]   in_inst, in_pc, imm_inst, imm_value, out_pc, out_imm;
    logic [5:0]       imm_type, out_type;
    logic [CNT_W-1:0] illegal_cnt;

    always #5 clk = ~clk;

    decode_imm_sched #(.LEN(LEN), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .imm_inst(imm_inst), .imm_type(imm_type), .imm_value(imm_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_type(out_type), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    // RV32 immediate generator. R returns the raw word so that a missing
    // zeroing of illegal entries is observable.
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [5:0] t);
        case (t)
            6'b100000: return i;
            6'b010000: return {{20{i[31]}}, i[31:20]};
            6'b001000: return {{20{i[31]}}, i[31:25], i[11:7]};
            6'b000100: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            6'b000010: return {i[31:12], 12'b0};
            6'b000001: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imm_value = imm_gen(imm_inst, imm_type);

    // Reference opcode table: returns {illegal, one-hot type}
    function automatic logic [6:0] m_decode(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op == 7'h33)                                  return 7'b0_100000;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67)   return 7'b0_010000;
        if (op == 7'h23)                                  return 7'b0_001000;
        if (op == 7'h63)                                  return 7'b0_000100;
        if (op == 7'h37 || op == 7'h17)                   return 7'b0_000010;
        if (op == 7'h6F)                                  return 7'b0_000001;
        return 7'b1_100000;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [5:0]  typ;
        logic [31:0] imm;
        logic        ill;
        int          age;   // clock edges seen since acceptance
    } ent_t;

    ent_t q[$];
    ent_t log_q[$];
    int   m_cnt   = 0;
    bit   started = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process + model update, both at the falling edge. Inputs are
    // stable from posedge+1 up to the next posedge, so values seen here are
    // the ones the next rising edge acts on.
    initial begin
        forever begin
            bit   exp_ir, exp_ov, a_present, in_fire, out_fire;
            logic [6:0] d;
            ent_t e;
            @(negedge clk);
            exp_ir    = !rst && !flush && !(q.size() == 2 && !out_ready);
            exp_ov    = (q.size() > 0) && (q[0].age >= 1);
            a_present = (q.size() == 2) || (q.size() == 1 && q[0].age == 0);
            if (started) begin
                chk("in_ready", in_ready, exp_ir);
                chk("out_valid", out_valid, exp_ov);
                chk("illegal_cnt", illegal_cnt, m_cnt);
                if (exp_ov) begin
                    chk("out_pc", out_pc, q[0].pc);
                    chk("out_type", out_type, q[0].typ);
                    chk("out_imm", out_imm, q[0].imm);
                    chk("out_illegal", out_illegal, q[0].ill);
                end
                if (a_present) begin
                    chk("imm_type", imm_type, q[q.size()-1].typ);
                    chk("imm_inst", imm_inst, q[q.size()-1].inst);
                end
                if (out_valid && out_ready && !flush && !rst) begin
                    e.inst = 0; e.pc = out_pc; e.typ = out_type;
                    e.imm = out_imm; e.ill = out_illegal; e.age = 0;
                    log_q.push_back(e);
                end
            end
            if (rst) begin
                q.delete();
                m_cnt   = 0;
                started = 1'b1;
            end else if (started) begin
                if (flush) begin
                    q.delete();
                end else begin
                    in_fire  = in_valid && exp_ir;
                    out_fire = exp_ov && out_ready;
                    if (out_fire) begin
                        if (q[0].ill && m_cnt != 255) m_cnt++;
                        void'(q.pop_front());
                    end
                    foreach (q[i]) q[i].age++;
                    if (in_fire) begin
                        d      = m_decode(in_inst);
                        e.inst = in_inst;
                        e.pc   = in_pc;
                        e.typ  = d[5:0];
                        e.ill  = d[6];
                        e.imm  = d[6] ? 32'h0 : imm_gen(in_inst, d[5:0]);
                        e.age  = 0;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) cyc();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic chk_reset_state();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_imm_type", imm_type, 6'b100000);
        chk("rst_imm_inst", imm_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_type", out_type, 6'b100000);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        cyc();
        chk("rst_in_ready_after", in_ready, 1'b1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        logic [31:0] w;
        int sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        w   = $urandom;
        sel = $urandom_range(0, 10);
        if (sel < 9) w[6:0] = ops[sel];
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk_reset_state();

        // Single addi
        log_q.delete();
        send(32'hFFF00093, 32'h100);
        @(negedge clk);
        chk("addi_stageA_type", imm_type, 6'b010000);
        cyc();
        drain();
        chk("addi_n", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("addi_pc", log_q[0].pc, 32'h100);
            chk("addi_type", log_q[0].typ, 6'b010000);
            chk("addi_imm", log_q[0].imm, 32'hFFFFFFFF);
        end

        // Back-to-back stream
        log_q.delete();
        send(32'h12345037, 32'h200);
        send(32'h0080006F, 32'h204);
        send(32'h00112223, 32'h208);
        send(32'hFE000EE3, 32'h20C);
        drain();
        chk("stream_n", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            chk("lui_type", log_q[0].typ, 6'b000010);
            chk("lui_imm", log_q[0].imm, 32'h12345000);
            chk("jal_type", log_q[1].typ, 6'b000001);
            chk("jal_imm", log_q[1].imm, 32'h00000008);
            chk("sw_type", log_q[2].typ, 6'b001000);
            chk("sw_imm", log_q[2].imm, 32'h00000004);
            chk("beq_type", log_q[3].typ, 6'b000100);
            chk("beq_pc", log_q[3].pc, 32'h20C);
        end

        // Back-pressure
        log_q.delete();
        out_ready = 1'b0;
        fork
            begin
                send(32'h00500113, 32'h300);
                send(32'h00600193, 32'h304);
                send(32'h00700213, 32'h308);
            end
            begin
                repeat (4) cyc();
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_n", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            chk("bp_pc0", log_q[0].pc, 32'h300);
            chk("bp_pc1", log_q[1].pc, 32'h304);
            chk("bp_pc2", log_q[2].pc, 32'h308);
        end

        // Single illegal
        log_q.delete();
        send(32'h0000007F, 32'h400);
        @(negedge clk);
        chk("ill_stageA_type", imm_type, 6'b100000);
        cyc();
        drain();
        chk("ill_cnt1", illegal_cnt, 1);
        if (log_q.size() >= 1) begin
            chk("ill_flag", log_q[0].ill, 1'b1);
            chk("ill_imm", log_q[0].imm, 32'h0);
        end

        // Flush with both stages full, illegal entry in B being handshaked
        out_ready = 1'b0;
        send(32'hABC0007F, 32'h500);
        send(32'h00100093, 32'h504);
        flush = 1'b1; out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_cnt", illegal_cnt, 1);
        cyc();
        log_q.delete();
        send(32'h00A00293, 32'h600);
        drain();
        chk("post_flush_n", log_q.size(), 1);
        if (log_q.size() >= 1) chk("post_flush_imm", log_q[0].imm, 32'h0000000A);

        // Saturation
        for (int k = 0; k < 300; k++) send({$urandom} | 32'h7F, 32'h1000 + 4 * k);
        drain();
        chk("cnt_saturated", illegal_cnt, 255);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h12345037, 32'h700);
        send(32'h00112223, 32'h704);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        chk_reset_state();
        log_q.delete();
        send(32'hFFF00093, 32'h800);
        drain();
        chk("post_rst_n", log_q.size(), 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
            rst       = ($urandom % 400) == 0;
            cyc();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
